// File: rtl/sprite_mixer_pkg.sv
// Shared types and constants for the sprite mixer and its priority mux.
package sprite_mixer_pkg;

    localparam int HIT_COUNT_W = 8;

    typedef logic [23:0] rgb24;

    typedef enum logic [1:0] {
        ST_ACTIVE = 2'd0,
        ST_LATCH  = 2'd1,
        ST_BLANK  = 2'd2
    } mix_state_e;

endpackage

// File: rtl/sprite_mixer_priority_mux.sv
// Combinational sprite priority selection: lowest-index layer with a hit wins,
// background colour when no layer hits. Non-hitting layer colours never pass.
module sprite_priority_mux
    import sprite_mixer_pkg::*;
#(
    parameter int   N_LAYERS = 4,
    parameter rgb24 BG_COLOR = 24'h000000
) (
    input  logic [N_LAYERS*24-1:0] layer_rgb,
    input  logic [N_LAYERS-1:0]    layer_hit,
    output rgb24                   pixel
);

    // Walk from the lowest priority upward so the lowest-index hit is assigned last.
    always_comb begin
        pixel = BG_COLOR;
        for (int k = N_LAYERS - 1; k >= 0; k--) begin
            if (layer_hit[k]) begin
                pixel = layer_rgb[24*k +: 24];
            end
        end
    end

endmodule

// File: rtl/sprite_mixer.sv
// Two-stage sprite mixer with per-frame player collision tracking.
// Collision FSM and counters are built only when SPRITE_MIXER_COLLISION_EN is defined.
module sprite_mixer
    import sprite_mixer_pkg::*;
#(
    parameter int   N_LAYERS = 4,
    parameter rgb24 BG_COLOR = 24'h000000
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_de,
    input  logic                   i_h_sync,
    input  logic                   i_v_sync,
    input  logic [N_LAYERS*24-1:0] i_layer_rgb,
    input  logic [N_LAYERS-1:0]    i_layer_hit,
    input  logic                   i_collision_clr,
    output logic [7:0]             o_red,
    output logic [7:0]             o_green,
    output logic [7:0]             o_blue,
    output logic                   o_de,
    output logic                   o_h_sync,
    output logic                   o_v_sync,
    output logic                   o_collision,
    output logic [HIT_COUNT_W-1:0] o_hit_count
);

    logic [N_LAYERS*24-1:0] rgb_p1;
    logic [N_LAYERS-1:0]    hit_p1;
    logic                   vld_p1;
    logic                   hs_p1;
    logic                   vs_p1;
    rgb24                   sel_p1;
    rgb24                   mix_p1;

    rgb24                   mix_p2;
    logic                   vld_p2;
    logic                   hs_p2;
    logic                   vs_p2;

    // Stage 1: input registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rgb_p1 <= '0;
            hit_p1 <= '0;
            vld_p1 <= 1'b0;
            hs_p1  <= 1'b0;
            vs_p1  <= 1'b0;
        end else begin
            rgb_p1 <= i_layer_rgb;
            hit_p1 <= i_layer_hit;
            vld_p1 <= i_de;
            hs_p1  <= i_h_sync;
            vs_p1  <= i_v_sync;
        end
    end

    sprite_priority_mux #(
        .N_LAYERS (N_LAYERS),
        .BG_COLOR (BG_COLOR)
    ) u_priority_mux (
        .layer_rgb (rgb_p1),
        .layer_hit (hit_p1),
        .pixel     (sel_p1)
    );

    assign mix_p1 = vld_p1 ? sel_p1 : '0;

    // Stage 2: mixed pixel and aligned timing
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            mix_p2 <= '0;
            vld_p2 <= 1'b0;
            hs_p2  <= 1'b0;
            vs_p2  <= 1'b0;
        end else begin
            mix_p2 <= mix_p1;
            vld_p2 <= vld_p1;
            hs_p2  <= hs_p1;
            vs_p2  <= vs_p1;
        end
    end

    assign o_red    = mix_p2[23:16];
    assign o_green  = mix_p2[15:8];
    assign o_blue   = mix_p2[7:0];
    assign o_de     = vld_p2;
    assign o_h_sync = hs_p2;
    assign o_v_sync = vs_p2;

`ifdef SPRITE_MIXER_COLLISION_EN
    function automatic logic [HIT_COUNT_W-1:0] sat_inc_count(input logic [HIT_COUNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    mix_state_e             state;
    logic                   collision_pending;
    logic                   collision_q;
    logic [HIT_COUNT_W-1:0] hit_count_q;
    logic                   overlap_p1;

    // Player sprite (layer 0) overlapping any other opaque layer on a visible pixel.
    assign overlap_p1 = vld_p1 & hit_p1[0] & (|(hit_p1 >> 1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state             <= ST_ACTIVE;
            collision_pending <= 1'b0;
            collision_q       <= 1'b0;
            hit_count_q       <= '0;
        end else begin
            // A clear is overridden below when it lands on the LATCH cycle.
            if (i_collision_clr) begin
                collision_q <= 1'b0;
            end
            case (state)
                ST_ACTIVE: begin
                    if (overlap_p1) begin
                        collision_pending <= 1'b1;
                    end
                    if (vs_p1 && !vs_p2) begin
                        state <= ST_LATCH;
                    end
                end
                ST_LATCH: begin
                    collision_q       <= collision_pending;
                    collision_pending <= 1'b0;
                    if (collision_pending) begin
                        hit_count_q <= sat_inc_count(hit_count_q);
                    end
                    state <= ST_BLANK;
                end
                ST_BLANK: begin
                    // Leave on v_sync low so a one-cycle v_sync pulse cannot strand the FSM.
                    if (!vs_p1) begin
                        state <= ST_ACTIVE;
                    end
                end
                default: state <= ST_ACTIVE;
            endcase
        end
    end

    assign o_collision = collision_q;
    assign o_hit_count = hit_count_q;
`else
    logic unused_collision_clr;
    assign unused_collision_clr = i_collision_clr;
    assign o_collision          = 1'b0;
    assign o_hit_count          = '0;
`endif

endmodule

// File: tb/tb_sprite_mixer.sv
// Scoreboard bench for sprite_mixer: pixel stream and per-frame collision results.
module tb_sprite_mixer;

    localparam int          NL = 4;
    localparam logic [23:0] BG = 24'h204060;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              de = 1'b0, hs = 1'b0, vs = 1'b0, clr = 1'b0;
    logic [NL*24-1:0]  lrgb = '0;
    logic [NL-1:0]     lhit = '0;
    logic [7:0]        r, g, b, ocnt;
    logic              ode, ohs, ovs, ocoll;

    sprite_mixer #(.N_LAYERS(NL), .BG_COLOR(BG)) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_de            (de),
        .i_h_sync        (hs),
        .i_v_sync        (vs),
        .i_layer_rgb     (lrgb),
        .i_layer_hit     (lhit),
        .i_collision_clr (clr),
        .o_red           (r),
        .o_green         (g),
        .o_blue          (b),
        .o_de            (ode),
        .o_h_sync        (ohs),
        .o_v_sync        (ovs),
        .o_collision     (ocoll),
        .o_hit_count     (ocnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        logic [23:0] rgb;
        logic        de;
        logic        hs;
        logic        vs;
    } pix_t;

    typedef struct {
        int         due;
        logic       coll;
        logic [7:0] cnt;
    } coll_t;

    pix_t  pix_q[$];
    coll_t coll_q[$];
    int    total = 0;
    int    bad = 0;
    bit    in_rst = 1'b1;

    // Frame-level reference state
    bit m_pend = 1'b0;
    bit m_coll = 1'b0;
    int m_cnt  = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at cycle %0d", name, got, exp, cyc);
        end
    endtask

    function automatic logic [23:0] ref_mix(input bit d, input logic [NL-1:0] hit,
                                            input logic [NL*24-1:0] rgb);
        if (!d) return 24'h000000;
        for (int k = 0; k < NL; k++) begin
            if (hit[k]) return rgb[24*k +: 24];
        end
        return BG;
    endfunction

    function automatic logic [NL*24-1:0] rand_rgb();
        logic [NL*24-1:0] v;
        for (int k = 0; k < NL; k++) v[24*k +: 24] = 24'($urandom);
        return v;
    endfunction

    task automatic drive(input bit d, input bit h, input bit v, input logic [NL-1:0] hit,
                         input logic [NL*24-1:0] rgb, input bit c);
        pix_t e;
        @(posedge clk);
        #1;
        de = d; hs = h; vs = v; lhit = hit; lrgb = rgb; clr = c;
        e.due = cyc + 2;
        e.rgb = ref_mix(d, hit, rgb);
        e.de  = d;
        e.hs  = h;
        e.vs  = v;
        pix_q.push_back(e);
        if (d && hit[0] && (hit[NL-1:1] != '0)) m_pend = 1'b1;
        if (c) m_coll = 1'b0;
    endtask

    task automatic push_coll();
        coll_t c;
        c.due = cyc;
`ifdef SPRITE_MIXER_COLLISION_EN
        c.coll = m_coll;
        c.cnt  = 8'(m_cnt);
`else
        c.coll = 1'b0;
        c.cnt  = 8'h00;
`endif
        coll_q.push_back(c);
    endtask

    // v_sync pulse with de low, latch applied to the model, then a short blank gap.
    task automatic vsync_frame(input bit clr_at_latch);
        for (int i = 0; i < 4; i++) drive(0, 0, 1, NL'($urandom), rand_rgb(), clr_at_latch && (i == 2));
        m_coll = m_pend;
        if (m_pend && m_cnt < 255) m_cnt++;
        m_pend = 1'b0;
        for (int i = 0; i < 3; i++) drive(0, 0, 0, NL'($urandom), rand_rgb(), 0);
        push_coll();
    endtask

    always @(negedge clk) begin
        pix_t  pe;
        coll_t ce;
        if (!in_rst) begin
            while (pix_q.size() > 0 && pix_q[0].due < cyc) begin
                pe = pix_q.pop_front();
                check("pix_missed", 32'(cyc), 32'(pe.due));
            end
            if (pix_q.size() > 0 && pix_q[0].due == cyc) begin
                pe = pix_q.pop_front();
                check("rgb", {8'h00, r, g, b}, {8'h00, pe.rgb});
                check("o_de", 32'(ode), 32'(pe.de));
                check("o_h_sync", 32'(ohs), 32'(pe.hs));
                check("o_v_sync", 32'(ovs), 32'(pe.vs));
            end
            if (coll_q.size() > 0 && coll_q[0].due <= cyc) begin
                ce = coll_q.pop_front();
                check("o_collision", 32'(ocoll), 32'(ce.coll));
                check("o_hit_count", 32'(ocnt), 32'(ce.cnt));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NL*24-1:0] v;
        int               npix;
        bit               no_player;

        repeat (2) @(posedge clk);
        #1;
        check("rst_rgb", {8'h00, r, g, b}, 32'h0);
        check("rst_sync", {29'h0, ode, ohs, ovs}, 32'h0);
        check("rst_coll", {23'h0, ocoll, ocnt}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_rst = 1'b0;

        // Background, priority and de-gating directed pixels
        drive(1, 0, 0, 4'b0000, rand_rgb(), 0);
        v = rand_rgb();
        v[24*1 +: 24] = 24'h9AD2FF;
        v[24*2 +: 24] = 24'h4F92B3;
        drive(1, 1, 0, 4'b0110, v, 0);
        drive(0, 0, 0, 4'b1111, rand_rgb(), 0);
        drive(0, 0, 0, 4'b0000, rand_rgb(), 0);
        vsync_frame(0);

        // Single overlap frame, then a clean frame
        drive(1, 0, 0, 4'b0101, rand_rgb(), 0);
        drive(0, 0, 0, 4'b0000, rand_rgb(), 0);
        vsync_frame(0);
        drive(1, 0, 0, 4'b0001, rand_rgb(), 0);
        drive(1, 0, 0, 4'b1110, rand_rgb(), 0);
        vsync_frame(0);

        // Clear outside LATCH
        drive(1, 0, 0, 4'b1001, rand_rgb(), 0);
        vsync_frame(0);
        drive(1, 0, 0, 4'b0000, rand_rgb(), 1);
        drive(1, 0, 0, 4'b0000, rand_rgb(), 0);
        push_coll();

        // Randomised frames
        for (int f = 0; f < 20; f++) begin
            npix = int'($urandom_range(10, 40));
            no_player = ($urandom % 3) == 0;
            for (int p = 0; p < npix; p++) begin
                logic [NL-1:0] hit;
                hit = NL'($urandom);
                if (no_player) hit[0] = 1'b0;
                drive(($urandom % 8) != 0, $urandom % 2, 0, hit, rand_rgb(), 0);
            end
            vsync_frame(0);
        end

        // Reset in the middle of a frame after an overlap
        drive(1, 0, 0, 4'b0101, rand_rgb(), 0);
        drive(1, 1, 0, 4'b0011, rand_rgb(), 0);
        #2;
        in_rst = 1'b1;
        pix_q.delete();
        coll_q.delete();
        rst = 1'b1;
        #1;
        check("midrst_rgb", {8'h00, r, g, b}, 32'h0);
        check("midrst_sync", {29'h0, ode, ohs, ovs}, 32'h0);
        check("midrst_coll", {23'h0, ocoll, ocnt}, 32'h0);
        de = 1'b0; hs = 1'b0; vs = 1'b0; clr = 1'b0; lhit = '0;
        m_pend = 1'b0;
        m_coll = 1'b0;
        m_cnt  = 0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        in_rst = 1'b0;
        drive(1, 0, 0, 4'b0100, rand_rgb(), 0);
        drive(1, 0, 0, 4'b0000, rand_rgb(), 0);
        vsync_frame(0);

        // Saturation, with a clear landing on the final LATCH cycle
        for (int f = 0; f < 300; f++) begin
            drive(1, 0, 0, 4'b0011, rand_rgb(), 0);
            drive(0, 0, 0, 4'b0000, rand_rgb(), 0);
            vsync_frame(f == 299);
        end
        drive(1, 0, 0, 4'b0000, rand_rgb(), 1);
        drive(1, 0, 0, 4'b0000, rand_rgb(), 0);
        push_coll();

        drive(0, 0, 0, 4'b0000, rand_rgb(), 0);
        repeat (5) @(posedge clk);
        #1;
        check("drain_pix", 32'(pix_q.size()), 32'h0);
        check("drain_coll", 32'(coll_q.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sprite_mixer.md
SPRITE_MIXER -- requirements
Module: sprite_mixer

Interface
REQ-001 SHALL have parameter N_LAYERS, default 4: number of sprite layers; layer 0 is the player sprite and has highest priority.
REQ-002 SHALL have parameter BG_COLOR, default 24'h000000: background RGB, {R,G,B}.
REQ-003 SHALL have port i_clk, input, 1: pixel clock.
REQ-004 SHALL have port i_rst, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port i_de, input, 1: active-video data enable.
REQ-006 SHALL have port i_h_sync, input, 1: horizontal sync, pass-through.
REQ-007 SHALL have port i_v_sync, input, 1: vertical sync, pass-through and frame marker.
REQ-008 SHALL have port i_layer_rgb, input, N_LAYERS*24: per-layer {R,G,B}, layer k at bits [24k+23:24k]; undefined when that layer's hit is 0.
REQ-009 SHALL have port i_layer_hit, input, N_LAYERS: per-layer opaque-pixel hit.
REQ-010 SHALL have port i_collision_clr, input, 1: clears o_collision.
REQ-011 SHALL have ports o_red, o_green, o_blue, output, 8 each: mixed pixel colour.
REQ-012 SHALL have ports o_de, o_h_sync, o_v_sync, output, 1 each: timing aligned to the mixed pixel.
REQ-013 SHALL have port o_collision, output, 1: sticky collision flag for the last completed frame.
REQ-014 SHALL have port o_hit_count, output, 8: count of frames containing a collision.

Function
REQ-015 SHALL register inputs in stage 1 and the mixed result in stage 2; latency from inputs to outputs SHALL be exactly 2 cycles, with no bubbles.
REQ-016 SHALL delay i_de, i_h_sync and i_v_sync by exactly 2 cycles so they align with the mixed pixel.
REQ-017 SHALL select the rgb of the lowest-index layer with hit=1; with no hit, BG_COLOR.
REQ-018 SHALL output 24'h000000 whenever the delayed de is 0, regardless of hits.
REQ-019 SHALL never propagate rgb from a layer whose hit is 0; an undefined rgb on such a layer SHALL not reach the outputs.
REQ-020 SHALL set internal collision_pending when stage-1 de=1, layer-0 hit=1 and any other layer hit=1.
REQ-021 SHALL run FSM states ACTIVE, LATCH and BLANK:
- ACTIVE: on a stage-1 v_sync rising edge, go to LATCH.
- LATCH: lasts 1 cycle, then goes to BLANK.
- BLANK: on stage-1 v_sync falling edge, go to ACTIVE.
REQ-022 In LATCH, SHALL perform all of:
- o_collision <= collision_pending.
- o_hit_count increments if collision_pending, saturating at 8'hFF.
- collision_pending clears.
REQ-023 SHALL hold o_collision between LATCH cycles; i_collision_clr clears it the next cycle.
REQ-024 When i_collision_clr and LATCH coincide, LATCH SHALL win.
REQ-025 SHALL count collisions only for pixels in stage-1 de=1; pending sets during BLANK are impossible by construction and SHALL be ignored.

Reset
REQ-026 On i_rst, SHALL asynchronously clear all of: pipeline registers, RGB outputs, o_de, o_h_sync, o_v_sync, o_collision, o_hit_count, collision_pending; FSM SHALL go to ACTIVE.
REQ-027 A reset asserted mid-frame SHALL discard the pending collision; the first LATCH after release SHALL reflect only post-reset pixels.

Configuration
REQ-028 SHALL use macro SPRITE_MIXER_COLLISION_EN:
- Defined: REQ-020 to REQ-025 are implemented.
- Undefined: no FSM or collision logic; o_collision and o_hit_count tied to 0; the mixing datapath and its 2-cycle latency are unchanged.

Structure
REQ-029 Shared package SHALL hold the rgb24 typedef, the mixer FSM state enum and the HIT_COUNT_W=8 constant.
REQ-030 Priority selection SHALL be a sub-module, sprite_priority_mux (combinational, N_LAYERS parameter); all registers and the FSM stay in sprite_mixer.

Verification
REQ-031 Drive de=1, hit=4'b0000 -> 2 cycles later RGB = BG_COLOR, o_de=1.
REQ-032 Drive hit=4'b0110, layer1=24'h9AD2FF, layer2=24'h4F92B3 -> output 9A/D2/FF exactly 2 cycles later.
REQ-033 Drive de=0, hit=4'b1111 -> RGB 00/00/00, and collision_pending stays 0.
REQ-034 Apply one pixel hit=4'b0101 with de=1, then a v_sync pulse:
- o_collision=1 and o_hit_count=1 after LATCH.
- Next frame without overlap: o_collision=0, o_hit_count=1.
REQ-035 Run 300 frames each with a collision -> o_hit_count saturates at 8'hFF; asserting i_collision_clr in the LATCH cycle leaves o_collision=1.
REQ-036 Assert i_rst mid-frame after an overlap -> all outputs 0 immediately; next LATCH gives o_collision=0.
